// File: rtl/fp_div_param.sv
// Sequential IEEE-754 divider: restoring division, one quotient bit per clock,
// with NaN/inf/zero short-cuts, subnormal handling and all five rounding modes.
module fp_div_param #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic [2:0]            rnd_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] z,
  output logic [4:0]            flags,
  output logic                  busy,
  output logic [3:0]            dbg_state
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int QW = FRAC_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);

  localparam logic [3:0] IDLE = 4'd0, UNPACK = 4'd1, SPECIAL = 4'd2, NORM_A = 4'd3,
                         NORM_B = 4'd4, DIV = 4'd5, NORM_Z = 4'd6, ROUND = 4'd7,
                         PACK = 4'd8, DONE = 4'd9;

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ONE_E = EW'(1);
  localparam logic signed [EW-1:0] MAX_E = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0]        QW_E  = EW'(QW);
  localparam logic [CW-1:0]        LAST_IT = CW'(QW - 2);
  localparam logic [EXP_W-1:0]     ONES  = {EXP_W{1'b1}};
  localparam logic [W-1:0]         QNAN  = {1'b0, ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  logic [3:0]                 state;
  logic [W-1:0]               a_r, b_r;
  logic [2:0]                 rm;
  logic                       sign;
  logic [MW-1:0]              ma, mb, mant_r;
  logic signed [EW-1:0]       ea, eb, ez;
  logic [MW:0]                rem;
  logic [QW-1:0]              q;
  logic [CW-1:0]              cnt;
  logic                       stk;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the producer holds its payload until then.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  always_comb begin
    exp_a  = a_r[W-2:FRAC_W];
    exp_b  = b_r[W-2:FRAC_W];
    frac_a = a_r[FRAC_W-1:0];
    frac_b = b_r[FRAC_W-1:0];
    zero_a = (exp_a == '0) && (frac_a == '0);
    zero_b = (exp_b == '0) && (frac_b == '0);
    inf_a  = (exp_a == ONES) && (frac_a == '0);
    inf_b  = (exp_b == ONES) && (frac_b == '0);
    nan_a  = (exp_a == ONES) && (frac_a != '0);
    nan_b  = (exp_b == ONES) && (frac_b != '0);
    snan_a = nan_a && !frac_a[FRAC_W-1];
    snan_b = nan_b && !frac_b[FRAC_W-1];
  end

  // First quotient bit is taken on the transition into DIV, using the operands
  // as they will look after this cycle's normalising shift.
  logic [MW-1:0] src_a, src_b;
  logic          ent_ge, div_ge;
  logic [MW:0]   ent_rem, div_next;
  logic [MW-1:0] div_sub;

  always_comb begin
    src_a = ma;
    src_b = mb;
    if (state == NORM_A) src_a = ma << 1;
    if (state == NORM_B) src_b = mb << 1;
    ent_ge   = src_a >= src_b;
    ent_rem  = {(ent_ge ? src_a - src_b : src_a), 1'b0};
    div_ge   = rem >= {1'b0, mb};
    div_sub  = rem[MW-1:0] - mb;
    div_next = {(div_ge ? div_sub : rem[MW-1:0]), 1'b0};
  end

  logic [QW-1:0]        qn, qs;
  logic signed [EW-1:0] en, en_f;
  logic [EW-1:0]        sh;
  logic                 lost;

  always_comb begin
    qn   = q[QW-1] ? q : (q << 1);
    en   = ea - eb + BIAS - (q[QW-1] ? '0 : ONE_E);
    sh   = ONE_E - en;
    qs   = qn;
    en_f = en;
    lost = 1'b0;
    if (en < ONE_E) begin
      en_f = ONE_E;
      if (sh >= QW_E) begin
        qs   = '0;
        lost = |qn;
      end else begin
        qs   = qn >> sh;
        lost = |(qn & ~({QW{1'b1}} << sh));
      end
    end
  end

  logic [2:0]           rm_eff;
  logic [MW-1:0]        mant, mant_f;
  logic                 g, rs, inc, nx, of, ovf_inf;
  logic [MW:0]          mr;
  logic signed [EW-1:0] e_f;

  always_comb begin
    rm_eff = (rm > 3'd4) ? 3'd0 : rm;
    mant   = q[QW-1:3];
    g      = q[2];
    rs     = q[1] | q[0] | stk;
    nx     = g | rs;
    case (rm_eff)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & nx;
      3'd3:    inc = !sign & nx;
      3'd4:    inc = g;
      default: inc = g & (rs | mant[0]);
    endcase
    mr = {1'b0, mant} + (MW+1)'(inc);
    if (mr[MW]) begin
      mant_f = mr[MW:1];
      e_f    = ez + ONE_E;
    end else begin
      mant_f = mr[MW-1:0];
      e_f    = ez;
    end
    of      = e_f >= MAX_E;
    ovf_inf = (rm_eff == 3'd0) || (rm_eff == 3'd4) ||
              ((rm_eff == 3'd3) && !sign) || ((rm_eff == 3'd2) && sign);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      z      <= '0;
      flags  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      rm     <= '0;
      sign   <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      mant_r <= '0;
      ea     <= '0;
      eb     <= '0;
      ez     <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      stk    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          rm    <= rnd_mode;
          flags <= '0;
          state <= UNPACK;
        end
        UNPACK: begin
          sign  <= a_r[W-1] ^ b_r[W-1];
          ma    <= {exp_a != '0, frac_a};
          mb    <= {exp_b != '0, frac_b};
          ea    <= (exp_a == '0) ? ONE_E - BIAS : $signed({2'b00, exp_a}) - BIAS;
          eb    <= (exp_b == '0) ? ONE_E - BIAS : $signed({2'b00, exp_b}) - BIAS;
          state <= SPECIAL;
        end
        SPECIAL: begin
          if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            z     <= QNAN;
            flags <= {snan_a || snan_b || (zero_a && zero_b) || (inf_a && inf_b), 4'b0000};
            state <= DONE;
          end else if (inf_a) begin
            z     <= {sign, ONES, {FRAC_W{1'b0}}};
            state <= DONE;
          end else if (inf_b || zero_a) begin
            z     <= {sign, {(W-1){1'b0}}};
            state <= DONE;
          end else if (zero_b) begin
            z     <= {sign, ONES, {FRAC_W{1'b0}}};
            flags <= 5'b01000;
            state <= DONE;
          end else if (!ma[MW-1]) begin
            state <= NORM_A;
          end else if (!mb[MW-1]) begin
            state <= NORM_B;
          end else begin
            rem   <= ent_rem;
            q     <= QW'(ent_ge);
            cnt   <= '0;
            state <= DIV;
          end
        end
        NORM_A: begin
          ma <= ma << 1;
          ea <= ea - ONE_E;
          if (ma[MW-2]) begin
            if (!mb[MW-1]) begin
              state <= NORM_B;
            end else begin
              rem   <= ent_rem;
              q     <= QW'(ent_ge);
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        NORM_B: begin
          mb <= mb << 1;
          eb <= eb - ONE_E;
          if (mb[MW-2]) begin
            rem   <= ent_rem;
            q     <= QW'(ent_ge);
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= div_next;
          q   <= {q[QW-2:0], div_ge};
          cnt <= cnt + CW'(1);
          if (cnt == LAST_IT) state <= NORM_Z;
        end
        NORM_Z: begin
          q     <= qs;
          ez    <= en_f;
          stk   <= (rem != '0) | lost;
          state <= ROUND;
        end
        ROUND: begin
          mant_r <= mant_f;
          ez     <= e_f;
          flags  <= {2'b00, of, !mant_f[MW-1] & nx, nx | of};
          state  <= PACK;
        end
        PACK: begin
          if (flags[2])
            z <= ovf_inf ? {sign, ONES, {FRAC_W{1'b0}}}
                         : {sign, ONES - EXP_W'(1), {FRAC_W{1'b1}}};
          else
            z <= {sign, (mant_r[MW-1] ? ez[EXP_W-1:0] : {EXP_W{1'b0}}), mant_r[FRAC_W-1:0]};
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_div_param.md
FP_DIV_PARAM -- requirements
Module: fp_div_param

Interface

Parameters:
- REQ-001: EXP_W, default 8, exponent field width; legal 5..11.
- REQ-002: FRAC_W, default 23, stored fraction width; legal 10..52.

Ports (W = 1+EXP_W+FRAC_W):
- REQ-003: clk  in  1  single clock; all state updates on rising edge.
- REQ-004: rst  in  1  reset, asynchronous, active-high.
- REQ-005: in_valid  in  1  operand pair and mode presented.
- REQ-006: in_ready  out  1  high only in IDLE; transfer when in_valid&&in_ready.
- REQ-007: a  in  W  IEEE-754 dividend.
- REQ-008: b  in  W  IEEE-754 divisor.
- REQ-009: rnd_mode  in  3  0=RNE, 1=RTZ, 2=RDN, 3=RUP, 4=RMM; 5..7 treated as RNE.
- REQ-010: out_valid  out  1  result and flags valid.
- REQ-011: out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready.
- REQ-012: z  out  W  quotient a/b.
- REQ-013: flags  out  5  {NV,DZ,OF,UF,NX}, sticky per operation only.
- REQ-014: busy  out  1  high in any state other than IDLE.

Function
- REQ-015: FSM states: IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIV, NORM_Z, ROUND, PACK, DONE.
- REQ-016: IDLE -> UNPACK on accepted input; a, b and rnd_mode are registered, and later input changes are ignored.
- REQ-017: SPECIAL handling, with priority top-down. For every special case SPECIAL -> DONE.
  - Any NaN operand, 0/0, or inf/inf -> canonical NaN (sign 0, exp all-ones, fraction MSB 1, rest 0).
  - Signalling-NaN input, 0/0 and inf/inf set NV.
  - inf/finite -> signed inf.
  - finite/inf -> signed zero.
  - 0/nonzero -> signed zero.
  - nonzero-finite/0 -> signed inf, DZ.
- REQ-018: Result sign for all non-NaN results = sign(a) XOR sign(b).
- REQ-019: Mantissa setup: normal operands get the hidden 1; subnormals use exponent 1-bias.
- REQ-020: NORM_A / NORM_B shift a subnormal mantissa left one bit per cycle until the MSB is set, decrementing the internal exponent each shift.
  - Internal exponent is signed, EXP_W+2 bits.
- REQ-021: DIV is restoring division, one quotient bit per cycle, FRAC_W+4 iterations.
  - Produces FRAC_W+2 significant bits plus guard and round.
  - Sticky = OR of nonzero remainder.
- REQ-022: Biased result exponent = ea - eb + bias.
- REQ-023: NORM_Z left-shifts once if the quotient MSB is clear.
  - If the exponent is below the minimum normal, NORM_Z right-shifts with sticky accumulation until exponent = min or the mantissa is zero.
- REQ-024: ROUND applies rnd_mode; a mantissa carry-out increments the exponent.
  - NX set if guard|round|sticky.
  - UF set if the result is tiny after rounding and NX.
- REQ-025: Overflow (exponent >= all-ones) sets OF and NX.
  - Result is inf for RNE/RMM, and for RUP with positive or RDN with negative sign.
  - Otherwise the result is the largest finite value of that sign.
- REQ-026: DONE asserts out_valid; z and flags are held stable while out_valid && !out_ready.
- REQ-027: DONE -> IDLE on the output transfer; in_ready rises the following cycle (no same-cycle accept in DONE).
- REQ-028: Latency, accept-to-out_valid:
  - Special cases: exactly 3 cycles.
  - Normal/normal: exactly FRAC_W+9 cycles.
  - Subnormal inputs: add one cycle per normalising shift.

Reset
- REQ-029: rst high forces, asynchronously: state=IDLE, out_valid=0, busy=0, in_ready=0 while rst high, z=0, flags=0.
- REQ-030: rst asserted mid-operation abandons the operation with no output transfer; in_ready=1 on the first clock after rst falls.

Verification (defaults, FRAC_W=23)
- REQ-031: 0x40C00000 / 0x40000000, RNE -> z=0x40400000, flags=0, out_valid 32 cycles after accept.
- REQ-032: 0x3F800000 / 0x40400000:
  - RNE -> 0x3EAAAAAB, NX.
  - RTZ -> 0x3EAAAAAA, NX.
- REQ-033: 0x3F800000 / 0x00000000 -> 0x7F800000, DZ.
- REQ-034: 0x00000000 / 0x80000000 -> 0x7FC00000, NV, 3 cycles after accept.
- REQ-035: 0x7F7FFFFF / 0x3F000000:
  - RNE -> 0x7F800000, OF|NX.
  - RTZ -> 0x7F7FFFFF, OF|NX.
- REQ-036: Backpressure and reset cases:
  - out_ready held low 10 cycles in DONE -> z and flags stable, in_ready=0.
  - rst pulsed during DIV -> no out_valid; the next accepted operation produces a correct result.
